// File: rtl/ac_mode_actuator.sv
// rtl/ac_mode_actuator.sv - air-conditioner load actuator with compressor lockout and fan purge
module ac_mode_actuator #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int MIN_OFF_S   = 3,
    parameter int FAN_RUNON_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_en,
    input  logic [1:0] mode,
    output logic       comp_on,
    output logic       heat_on,
    output logic       fan_on,
    output logic       dry_valve,
    output logic       busy,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2,
        S_PURGE = 2'd3
    } state_t;

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]    LOCK_INIT = 16'(MIN_OFF_S);
    localparam logic [15:0]    PURGE_INIT = 16'(FAN_RUNON_S);

    state_t        state;
    state_t        state_n;
    logic [1:0]    mode_q;
    logic [1:0]    mode_n;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   lockout;
    logic [15:0]   purge;
    logic          purge_load;
    logic          lock_zero;
    logic          purge_done;
    logic          comp_n;
    logic          heat_n;
    logic          fan_n;
    logic          valve_n;
    logic          busy_n;

    function automatic logic needs_comp(input logic [1:0] m);
        return m[0] ^ m[1];
    endfunction

    assign tick = (presc == PRESC_MAX);

    // "Zero" includes the cycle a counter is about to reach zero, so the
    // transition lands on the same edge as the final tick.
    assign lock_zero  = (lockout == 16'd0) || (tick && lockout == 16'd1);
    assign purge_done = (purge == 16'd0) || (tick && purge == 16'd1);

    always_comb begin
        state_n    = state;
        mode_n     = mode_q;
        purge_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (power_en) begin
                    mode_n  = mode;
                    state_n = (needs_comp(mode) && !lock_zero) ? S_WAIT : S_RUN;
                end
            end
            S_WAIT: begin
                if (!power_en) begin
                    state_n = S_IDLE;
                end else begin
                    mode_n  = mode;
                    state_n = (!needs_comp(mode) || lock_zero) ? S_RUN : S_WAIT;
                end
            end
            S_RUN: begin
                if (!power_en || mode != mode_q) begin
                    state_n    = S_PURGE;
                    purge_load = 1'b1;
                end
            end
            S_PURGE: begin
                if (purge_done) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Loads are decoded from the next state so they switch on the transition edge.
    always_comb begin
        comp_n  = 1'b0;
        heat_n  = 1'b0;
        fan_n   = 1'b0;
        valve_n = 1'b0;
        busy_n  = 1'b0;
        case (state_n)
            S_WAIT, S_PURGE: begin
                fan_n  = 1'b1;
                busy_n = 1'b1;
            end
            S_RUN: begin
                fan_n   = 1'b1;
                comp_n  = needs_comp(mode_n);
                heat_n  = (mode_n == 2'b11);
                valve_n = (mode_n == 2'b01);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_q    <= 2'b00;
            presc     <= '0;
            lockout   <= LOCK_INIT;
            purge     <= 16'd0;
            comp_on   <= 1'b0;
            heat_on   <= 1'b0;
            fan_on    <= 1'b0;
            dry_valve <= 1'b0;
            busy      <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + PW'(1);
            state  <= state_n;
            mode_q <= mode_n;

            if (comp_on && !comp_n) begin
                lockout <= LOCK_INIT;
            end else if (tick && lockout != 16'd0) begin
                lockout <= lockout - 16'd1;
            end

            if (purge_load) begin
                purge <= PURGE_INIT;
            end else if (state == S_PURGE && tick && purge != 16'd0) begin
                purge <= purge - 16'd1;
            end

            comp_on   <= comp_n;
            heat_on   <= heat_n;
            fan_on    <= fan_n;
            dry_valve <= valve_n;
            busy      <= busy_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ac_mode_actuator.sv
// tb/tb_ac_mode_actuator.sv - directed vector bench for ac_mode_actuator
module tb_ac_mode_actuator;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_en;
    logic [1:0] mode;
    logic       comp_on;
    logic       heat_on;
    logic       fan_on;
    logic       dry_valve;
    logic       busy;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    ac_mode_actuator #(
        .TICK_DIV   (4),
        .MIN_OFF_S  (3),
        .FAN_RUNON_S(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .power_en (power_en),
        .mode     (mode),
        .comp_on  (comp_on),
        .heat_on  (heat_on),
        .fan_on   (fan_on),
        .dry_valve(dry_valve),
        .busy     (busy),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pe;
        logic [1:0] mode;
        int         n;
        logic [6:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [6:0] pack_exp(input logic c, input logic h, input logic f,
                                            input logic v, input logic b, input logic [1:0] s);
        return {c, h, f, v, b, s};
    endfunction

    task automatic add(input logic r, input logic p, input logic [1:0] m, input int n,
                       input logic c, input logic h, input logic f, input logic v,
                       input logic b, input logic [1:0] s);
        vec_t e;
        e.rst  = r;
        e.pe   = p;
        e.mode = m;
        e.n    = n;
        e.exp  = pack_exp(c, h, f, v, b, s);
        vq.push_back(e);
    endtask

    // One clock, sampled on the falling edge, with the load interlocks checked every cycle.
    task automatic step();
        @(negedge clk);
        checks++;
        if ((comp_on && heat_on) || (comp_on && !fan_on) || (dry_valve && !comp_on)) begin
            errors++;
            $display("FAIL interlock t=%0t comp=%b heat=%b fan=%b valve=%b", $time,
                     comp_on, heat_on, fan_on, dry_valve);
        end
    endtask

    initial begin
        logic [6:0] got;
        int         cnt;

        rst      = 1'b1;
        power_en = 1'b0;
        mode     = 2'b00;

        //   rst pe mode n   comp heat fan valve busy state
        add(1, 0, 2'b00, 2,  0, 0, 0, 0, 0, 2'd0);  // reset state
        add(0, 1, 2'b10, 1,  0, 0, 1, 0, 1, 2'd1);  // power-up lockout: WAIT
        add(0, 1, 2'b10, 10, 0, 0, 1, 0, 1, 2'd1);  // still WAIT at 11 clk
        add(0, 1, 2'b10, 1,  1, 0, 1, 0, 0, 2'd2);  // RUN on 3rd tick, 12 clk
        add(0, 0, 2'b10, 1,  0, 0, 1, 0, 1, 2'd3);  // power off -> PURGE
        add(0, 0, 2'b10, 6,  0, 0, 1, 0, 1, 2'd3);  // purge still running
        add(0, 0, 2'b10, 1,  0, 0, 0, 0, 0, 2'd0);  // IDLE after 2 ticks
        add(0, 1, 2'b10, 1,  0, 0, 1, 0, 1, 2'd1);  // restart waits remaining lockout
        add(0, 1, 2'b10, 3,  1, 0, 1, 0, 0, 2'd2);  // cool RUN
        add(0, 1, 2'b01, 1,  0, 0, 1, 0, 1, 2'd3);  // 10->01 -> PURGE
        add(0, 1, 2'b01, 7,  0, 0, 0, 0, 0, 2'd0);  // IDLE
        add(0, 1, 2'b01, 1,  0, 0, 1, 0, 1, 2'd1);  // WAIT for lockout
        add(0, 1, 2'b01, 3,  1, 0, 1, 1, 0, 2'd2);  // dehumidify RUN
        add(1, 1, 2'b01, 1,  0, 0, 0, 0, 0, 2'd0);  // rst mid-RUN
        add(0, 1, 2'b10, 1,  0, 0, 1, 0, 1, 2'd1);  // lockout reloaded by reset
        add(0, 1, 2'b10, 10, 0, 0, 1, 0, 1, 2'd1);
        add(0, 1, 2'b10, 1,  1, 0, 1, 0, 0, 2'd2);  // 3 ticks again
        add(0, 1, 2'b01, 1,  0, 0, 1, 0, 1, 2'd3);
        add(0, 1, 2'b01, 7,  0, 0, 0, 0, 0, 2'd0);
        add(0, 1, 2'b01, 1,  0, 0, 1, 0, 1, 2'd1);  // WAIT latched 01
        add(0, 1, 2'b00, 1,  0, 0, 1, 0, 0, 2'd2);  // 01->00 in WAIT: fan-only RUN
        add(1, 0, 2'b00, 1,  0, 0, 0, 0, 0, 2'd0);
        add(0, 1, 2'b11, 1,  0, 1, 1, 0, 0, 2'd2);  // heat starts, lockout ignored
        add(0, 1, 2'b00, 1,  0, 0, 1, 0, 1, 2'd3);  // heat -> PURGE
        add(0, 1, 2'b11, 5,  0, 0, 1, 0, 1, 2'd3);  // mode change ignored in PURGE
        add(0, 1, 2'b11, 1,  0, 0, 0, 0, 0, 2'd0);  // tick and purge 0 same cycle
        add(0, 1, 2'b11, 1,  0, 1, 1, 0, 0, 2'd2);  // IDLE re-evaluates: heat

        foreach (vq[i]) begin
            rst      = vq[i].rst;
            power_en = vq[i].pe;
            mode     = vq[i].mode;
            for (int k = 0; k < vq[i].n; k++) step();
            got = {comp_on, heat_on, fan_on, dry_valve, busy, state_o};
            checks++;
            if (got !== vq[i].exp) begin
                errors++;
                $display("FAIL vec%0d {comp,heat,fan,valve,busy,state} got=%b want=%b",
                         i, got, vq[i].exp);
            end
        end

        // Restart after reset in cool mode: comp_on must appear exactly 12 clocks later.
        rst      = 1'b1;
        power_en = 1'b0;
        step();
        rst      = 1'b0;
        power_en = 1'b1;
        mode     = 2'b10;
        cnt      = 0;
        while (!comp_on && cnt < 40) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != 12) begin
            errors++;
            $display("FAIL lockout_latency got=%0d clk want=12 clk", cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
